alarm_clock_ctrl: RTL and testbench
===================================

// Module: alarm_clock_ctrl
// PURPOSE
//  Timekeeping and alarm sequencer driven by the 1-cycle tick pulse of the clock divider.
//  Keeps HH:MM:SS and an HH:MM alarm time, and runs a mode FSM for setting time and alarm.
//  Raises and times out the alarm output.
//  Sits between the divider (tick source) and the display/buzzer logic.
// PARAMETERS
//  ALARM_LEN   60  ticks alarm_on stays high if not stopped (1..255)
//  ALM_RST_HR  7   alarm hour loaded at reset (0..23)
// PORTS
//  clk         in   1  system clock; all state changes on posedge
//  rst         in   1  asynchronous, active-low reset (0 = reset)
//  tick        in   1  1-cycle pulse, 1 Hz, from divider
//  mode_btn    in   1  1-cycle pulse, pre-debounced: advance FSM
//  inc_btn     in   1  1-cycle pulse, pre-debounced: increment selected field
//  alarm_en    in   1  level: 1 = alarm armed
//  alarm_stop  in   1  1-cycle pulse: silence alarm
//  hours       out  5  current hour 0..23
//  minutes     out  6  current minute 0..59
//  seconds     out  6  current second 0..59
//  alm_hours   out  5  alarm hour 0..23
//  alm_minutes out  6  alarm minute 0..59
//  state       out  3  FSM state encoding (below)
//  blink       out  1  display blink for the selected field
//  alarm_on    out  1  buzzer enable
// BEHAVIOUR
//  Reset (rst=0, async):
//   - time = 00:00:00; alarm = ALM_RST_HR:00.
//   - state = RUN; blink = 0; alarm_on = 0; alarm tick counter = 0.
//  FSM states: RUN=0, SET_HR=1, SET_MIN=2, SET_AHR=3, SET_AMIN=4.
//   - mode_btn moves RUN->SET_HR->SET_MIN->SET_AHR->SET_AMIN->RUN; each move takes effect at the next edge.
//   - Encodings 5..7 are illegal and go to RUN on the next edge.
//  Timekeeping: on an edge with tick=1 in RUN, SET_AHR or SET_AMIN:
//   - seconds increments.
//   - 59->0 carries to minutes; 59->0 carries to hours; 23->0 wraps. Cascade completes in that same edge.
//   - In SET_HR and SET_MIN, tick is ignored (time frozen).
//  Setting: inc_btn increments only the field selected by state, modulo its range, with no carry.
//   - Fields: hours (SET_HR), minutes (SET_MIN), alm_hours (SET_AHR), alm_minutes (SET_AMIN).
//   - inc_btn in RUN is ignored.
//   - seconds is cleared to 0 on the SET_MIN->SET_AHR transition.
//  Priority in one cycle: mode_btn beats inc_btn; the inc is dropped.
//  blink: 0 in RUN. In set states it toggles on each tick and is forced to 1 on entering a set state.
//  Alarm trigger: in RUN with alarm_en=1 and tick=1, if the post-increment time equals alm_hours:alm_minutes:00,
//   alarm_on=1 from that edge and the counter is cleared.
//  Alarm duration:
//   - While alarm_on=1, each tick increments the counter.
//   - On reaching ALARM_LEN, alarm_on->0 in that same edge.
//  Alarm clearing:
//   - alarm_stop=1, alarm_en=0 or leaving RUN clears alarm_on at the next edge.
//   - Any of these beats a trigger in the same cycle.
//   - A retrigger while alarm_on=1 restarts the counter.
//  Time never exceeds range; each ±1 transition is a single-edge update, no intermediate values.
// TESTING
//  T1 reset: assert rst=0 mid-count -> 00:00:00, alarm 07:00, state=0, alarm_on=0 immediately (no clk edge).
//  T2 wrap: set time 23:59 (seconds cleared) -> return to RUN, 60 ticks -> 00:00:00, no glitch.
//  T3 set: RUN, mode x2 (SET_MIN), minutes=58, inc x3 -> minutes=01, hours unchanged; tick during set ignored.
//  T4 alarm: alarm 07:00, time 06:59:59, alarm_en=1, tick -> 07:00:00, alarm_on=1; 60 more ticks -> alarm_on=0.
//  T5 stop race: alarm_stop asserted on the trigger cycle -> alarm_on stays 0; mode+inc same cycle -> only mode acts.
//  T6 leave-RUN: alarm_on=1, mode_btn -> alarm_on=0 next edge, state=SET_HR, blink=1.

Source files
------------

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock controller: HH:MM:SS timekeeping, HH:MM alarm, set-mode FSM and buzzer timing.
module alarm_clock_ctrl #(
    parameter int unsigned ALARM_LEN  = 60,
    parameter int unsigned ALM_RST_HR = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       alarm_en,
    input  logic       alarm_stop,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [4:0] alm_hours,
    output logic [5:0] alm_minutes,
    output logic [2:0] state,
    output logic       blink,
    output logic       alarm_on
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HR   = 3'd1,
        SET_MIN  = 3'd2,
        SET_AHR  = 3'd3,
        SET_AMIN = 3'd4
    } state_t;

    localparam logic [7:0] LEN    = 8'(ALARM_LEN);
    localparam logic [4:0] RST_HR = 5'(ALM_RST_HR);

    state_t     state_q, state_d;
    logic [4:0] hours_d, alm_hours_d;
    logic [5:0] minutes_d, seconds_d, alm_minutes_d;
    logic       blink_d, alarm_on_d;
    logic [7:0] cnt_q, cnt_d;

    logic [4:0] hr_nx;
    logic [5:0] min_nx, sec_nx;
    logic       time_run;
    logic       trigger;
    logic       clear;

    assign state = state_q;

    // Post-tick time with the full seconds->minutes->hours carry chain
    always_comb begin
        sec_nx = (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
        min_nx = minutes;
        hr_nx  = hours;
        if (seconds == 6'd59) begin
            min_nx = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
            if (minutes == 6'd59) begin
                hr_nx = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
            end
        end
    end

    // Next-state, field setting, blink and alarm sequencing
    always_comb begin
        state_d       = state_q;
        hours_d       = hours;
        minutes_d     = minutes;
        seconds_d     = seconds;
        alm_hours_d   = alm_hours;
        alm_minutes_d = alm_minutes;
        blink_d       = blink;
        alarm_on_d    = alarm_on;
        cnt_d         = cnt_q;
        clear         = 1'b0;

        time_run = (state_q == RUN) || (state_q == SET_AHR) || (state_q == SET_AMIN);
        if (tick && time_run) begin
            seconds_d = sec_nx;
            minutes_d = min_nx;
            hours_d   = hr_nx;
        end

        case (state_q)
            RUN: begin
                blink_d = 1'b0;
                if (mode_btn) begin
                    state_d = SET_HR;
                    blink_d = 1'b1;
                end
            end
            SET_HR: begin
                if (mode_btn) begin
                    state_d = SET_MIN;
                    blink_d = 1'b1;
                end else begin
                    if (inc_btn) hours_d = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                    if (tick) blink_d = ~blink;
                end
            end
            SET_MIN: begin
                if (mode_btn) begin
                    state_d   = SET_AHR;
                    blink_d   = 1'b1;
                    seconds_d = 6'd0;
                end else begin
                    if (inc_btn) minutes_d = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                    if (tick) blink_d = ~blink;
                end
            end
            SET_AHR: begin
                if (mode_btn) begin
                    state_d = SET_AMIN;
                    blink_d = 1'b1;
                end else begin
                    if (inc_btn) alm_hours_d = (alm_hours == 5'd23) ? 5'd0 : alm_hours + 5'd1;
                    if (tick) blink_d = ~blink;
                end
            end
            SET_AMIN: begin
                if (mode_btn) begin
                    state_d = RUN;
                    blink_d = 1'b0;
                end else begin
                    if (inc_btn) alm_minutes_d = (alm_minutes == 6'd59) ? 6'd0 : alm_minutes + 6'd1;
                    if (tick) blink_d = ~blink;
                end
            end
            default: begin
                state_d = RUN;
                blink_d = 1'b0;
            end
        endcase

        // Silencing conditions win over a trigger; a trigger wins over timeout counting
        trigger = (state_q == RUN) && alarm_en && tick && (hr_nx == alm_hours) &&
                  (min_nx == alm_minutes) && (sec_nx == 6'd0);
        clear   = alarm_stop || !alarm_en || (state_d != RUN);
        if (clear) begin
            alarm_on_d = 1'b0;
            cnt_d      = 8'd0;
        end else if (trigger) begin
            alarm_on_d = 1'b1;
            cnt_d      = 8'd0;
        end else if (alarm_on && tick) begin
            if (cnt_q + 8'd1 == LEN) begin
                alarm_on_d = 1'b0;
                cnt_d      = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            hours       <= 5'd0;
            minutes     <= 6'd0;
            seconds     <= 6'd0;
            alm_hours   <= RST_HR;
            alm_minutes <= 6'd0;
            blink       <= 1'b0;
            alarm_on    <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            hours       <= hours_d;
            minutes     <= minutes_d;
            seconds     <= seconds_d;
            alm_hours   <= alm_hours_d;
            alm_minutes <= alm_minutes_d;
            blink       <= blink_d;
            alarm_on    <= alarm_on_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Scoreboard bench for alarm_clock_ctrl: directed stimulus pushes hand-computed snapshots, monitor compares.
module tb_alarm_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       alarm_en = 1'b0;
    logic       alarm_stop = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [4:0] alm_hours;
    logic [5:0] alm_minutes;
    logic [2:0] state;
    logic       blink;
    logic       alarm_on;

    logic       probe = 1'b0;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [4:0] ah;
        logic [5:0] am;
        logic [2:0] st;
        logic       bl;
        logic       al;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    alarm_clock_ctrl #(.ALARM_LEN(60), .ALM_RST_HR(7)) dut (
        .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .alarm_en(alarm_en), .alarm_stop(alarm_stop), .hours(hours), .minutes(minutes),
        .seconds(seconds), .alm_hours(alm_hours), .alm_minutes(alm_minutes),
        .state(state), .blink(blink), .alarm_on(alarm_on)
    );

    always #5 clk = ~clk;

    // One clock cycle with the given pulses; pulses drop 1ns after the edge
    task automatic step(input logic tk, input logic md, input logic ic, input logic sp);
        tick       = tk;
        mode_btn   = md;
        inc_btn    = ic;
        alarm_stop = sp;
        @(posedge clk);
        #1;
        tick       = 1'b0;
        mode_btn   = 1'b0;
        inc_btn    = 1'b0;
        alarm_stop = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic modes(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic exp_push(input string nm, input int h, input int m, input int s, input int ah,
                            input int am, input int st, input int bl, input int al);
        snap_t e;
        e.h  = 5'(h);
        e.m  = 6'(m);
        e.s  = 6'(s);
        e.ah = 5'(ah);
        e.am = 6'(am);
        e.st = 3'(st);
        e.bl = 1'(bl);
        e.al = 1'(al);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Asynchronous check: pops the pending entry without waiting for a clock edge
    task automatic probe_now();
        probe = 1'b1;
        #1;
        probe = 1'b0;
    endtask

    // Monitor: compares DUT outputs against the oldest expected snapshot
    initial begin
        snap_t a;
        snap_t e;
        string nm;
        forever begin
            @(negedge clk or posedge probe);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a.h  = hours;
                a.m  = minutes;
                a.s  = seconds;
                a.ah = alm_hours;
                a.am = alm_minutes;
                a.st = state;
                a.bl = blink;
                a.al = alarm_on;
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %0d:%0d:%0d alm %0d:%0d st=%0d blink=%0b alarm_on=%0b, expected %0d:%0d:%0d alm %0d:%0d st=%0d blink=%0b alarm_on=%0b",
                             nm, a.h, a.m, a.s, a.ah, a.am, a.st, a.bl, a.al,
                             e.h, e.m, e.s, e.ah, e.am, e.st, e.bl, e.al);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        #1 rst = 1'b0;
        #1 exp_push("reset", 0, 0, 0, 7, 0, 0, 0, 0);
        probe_now();
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic counting, then set minutes with wrap and a frozen tick
        ticks(3);
        exp_push("run_tick", 0, 0, 3, 7, 0, 0, 0, 0);
        modes(1);
        exp_push("enter_set_hr", 0, 0, 3, 7, 0, 1, 1, 0);
        modes(1);
        incs(58);
        ticks(1);
        exp_push("tick_frozen", 0, 58, 3, 7, 0, 2, 0, 0);
        incs(3);
        exp_push("min_wrap_inc", 0, 1, 3, 7, 0, 2, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        exp_push("mode_beats_inc", 0, 1, 0, 7, 0, 3, 1, 0);
        ticks(1);
        exp_push("ahr_time_runs", 0, 1, 1, 7, 0, 3, 0, 0);
        modes(2);
        exp_push("back_run", 0, 1, 1, 7, 0, 0, 0, 0);

        // Midnight wrap from 23:59:00
        modes(1);
        incs(23);
        modes(1);
        incs(58);
        exp_push("set_2359", 23, 59, 1, 7, 0, 2, 1, 0);
        modes(3);
        exp_push("run_2359", 23, 59, 0, 7, 0, 0, 0, 0);
        ticks(59);
        exp_push("pre_wrap", 23, 59, 59, 7, 0, 0, 0, 0);
        ticks(1);
        exp_push("midnight_wrap", 0, 0, 0, 7, 0, 0, 0, 0);

        // Alarm at 07:00, full-length timeout
        modes(1);
        incs(6);
        modes(1);
        incs(59);
        modes(3);
        alarm_en = 1'b1;
        ticks(59);
        exp_push("pre_alarm", 6, 59, 59, 7, 0, 0, 0, 0);
        ticks(1);
        exp_push("alarm_trig", 7, 0, 0, 7, 0, 0, 0, 1);
        ticks(59);
        exp_push("alarm_held", 7, 0, 59, 7, 0, 0, 0, 1);
        ticks(1);
        exp_push("alarm_timeout", 7, 1, 0, 7, 0, 0, 0, 0);

        // Alarm at 07:02, then leave RUN while ringing
        modes(4);
        incs(2);
        modes(1);
        exp_push("alarm_set", 7, 1, 0, 7, 2, 0, 0, 0);
        ticks(60);
        exp_push("alarm_trig2", 7, 2, 0, 7, 2, 0, 0, 1);
        modes(1);
        exp_push("leave_run", 7, 2, 0, 7, 2, 1, 1, 0);

        // Stop pulse on the trigger cycle suppresses the alarm
        modes(3);
        incs(1);
        modes(1);
        ticks(59);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        exp_push("stop_race", 7, 3, 0, 7, 3, 0, 0, 0);

        // Stop pulse while ringing
        modes(4);
        incs(1);
        modes(1);
        ticks(60);
        exp_push("alarm_trig3", 7, 4, 0, 7, 4, 0, 0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp_push("stop_clear", 7, 4, 0, 7, 4, 0, 0, 0);

        // Asynchronous reset mid-count, observed before any clock edge
        ticks(5);
        exp_push("pre_reset", 7, 4, 5, 7, 4, 0, 0, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 exp_push("async_reset", 0, 0, 0, 7, 0, 0, 0, 0);
        probe_now();
        @(negedge clk);
        #1 rst = 1'b1;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected snapshots never compared, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
